// File: rtl/stopwatch_bcd_multi_if.sv
// Button inputs and display/status outputs of the multi-digit BCD stopwatch.
// The master side drives the synchronised buttons; the slave side is the stopwatch core.
interface stopwatch_bcd_multi_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      i_start_stop;
    logic                      i_lap;
    logic                      i_clear;
    logic [4*NUM_DIGITS-1:0]   o_bcd;
    logic [7*NUM_DIGITS-1:0]   o_seg;
    logic                      o_running;
    logic                      o_lap_active;
    logic                      o_overflow;

    modport master (
        output i_start_stop,
        output i_lap,
        output i_clear,
        input  o_bcd,
        input  o_seg,
        input  o_running,
        input  o_lap_active,
        input  o_overflow
    );

    modport slave (
        input  i_start_stop,
        input  i_lap,
        input  i_clear,
        output o_bcd,
        output o_seg,
        output o_running,
        output o_lap_active,
        output o_overflow
    );
endinterface

// File: rtl/stopwatch_bcd_multi.sv
// N-digit BCD stopwatch: prescaler, run/stop/lap FSM, cascaded decade counters,
// lap freeze register and registered 7-segment decode. i_reset is async, active-low.
module stopwatch_bcd_multi #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int WRAP_MODE  = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    stopwatch_bcd_multi_if.slave   sw
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic WRAP = (WRAP_MODE != 0);

    typedef enum logic [1:0] {
        S_STOP = 2'd0,
        S_RUN  = 2'd1,
        S_LAP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic          r_ss_q;
    logic          r_lap_q;
    logic          r_clr_q;
    logic [PW-1:0] r_presc;
    logic          r_running;
    logic          r_lap_active;
    logic          r_overflow;

    logic                  w_ss_edge;
    logic                  w_lap_edge;
    logic                  w_clr_edge;
    logic                  w_clr_apply;
    logic                  w_enable;
    logic                  w_tick;
    logic                  w_terminal;
    logic                  w_hold;
    logic                  w_snap;
    logic [NUM_DIGITS:0]   w_carry;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_ss_edge   = sw.i_start_stop & ~r_ss_q;
    assign w_lap_edge  = sw.i_lap & ~r_lap_q;
    assign w_clr_edge  = sw.i_clear & ~r_clr_q;
    assign w_clr_apply = w_clr_edge && (r_state == S_STOP);

    // Counting is gated by the registered state, so a stop edge still lets this cycle's tick count.
    assign w_enable = (r_state != S_STOP);
    assign w_tick   = w_enable && (r_presc == PRESC_LAST);

    assign w_carry[0] = w_tick;
    assign w_terminal = w_carry[NUM_DIGITS];
    assign w_hold     = w_terminal && !WRAP;

    always_comb begin
        w_state_next = r_state;
        w_snap       = 1'b0;
        case (r_state)
            S_STOP: begin
                if (w_ss_edge) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_ss_edge) begin
                    w_state_next = S_STOP;
                end else if (w_lap_edge) begin
                    w_state_next = S_LAP;
                    w_snap       = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ss_edge)       w_state_next = S_STOP;
                else if (w_lap_edge) w_state_next = S_RUN;
            end
            default: w_state_next = S_STOP;
        endcase
        // Saturating at all-9s forces a stop and releases any lap freeze.
        if (w_hold) w_state_next = S_STOP;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state      <= S_STOP;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
            r_ss_q       <= 1'b0;
            r_lap_q      <= 1'b0;
            r_clr_q      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_running    <= (w_state_next != S_STOP);
            r_lap_active <= (w_state_next == S_LAP);
            r_ss_q       <= sw.i_start_stop;
            r_lap_q      <= sw.i_lap;
            r_clr_q      <= sw.i_clear;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_presc    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_clr_apply) begin
                r_presc <= '0;
            end else if (w_enable) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            end

            if (w_clr_apply)     r_overflow <= 1'b0;
            else if (w_terminal) r_overflow <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] r_digit;
            logic [3:0] r_lap_digit;
            logic [6:0] r_seg;
            logic [3:0] w_shown;

            // A digit advances only when every lower digit is at 9 on a tick.
            assign w_carry[gi+1] = w_carry[gi] & (r_digit == 4'd9);
            assign w_shown       = (r_state == S_LAP) ? r_lap_digit : r_digit;

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    r_digit     <= 4'd0;
                    r_lap_digit <= 4'd0;
                    r_seg       <= 7'h3F;
                end else begin
                    if (w_clr_apply) begin
                        r_digit <= 4'd0;
                    end else if (w_carry[gi] && !w_hold) begin
                        r_digit <= (r_digit == 4'd9) ? 4'd0 : r_digit + 4'd1;
                    end
                    if (w_snap) r_lap_digit <= r_digit;
                    r_seg <= seg_decode(w_shown);
                end
            end

            assign sw.o_bcd[4*gi +: 4] = r_digit;
            assign sw.o_seg[7*gi +: 7] = r_seg;
        end
    endgenerate

    assign sw.o_running    = r_running;
    assign sw.o_lap_active = r_lap_active;
    assign sw.o_overflow   = r_overflow;

endmodule

// File: tb/tb_stopwatch_bcd_multi.sv
// Directed bench for the BCD stopwatch: a wrapping and a saturating instance
// (2 digits, prescale 4) share the same button stimulus and are checked via a scoreboard.
module tb_stopwatch_bcd_multi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stopwatch_bcd_multi_if #(.NUM_DIGITS(2)) if_w ();
    stopwatch_bcd_multi_if #(.NUM_DIGITS(2)) if_s ();

    stopwatch_bcd_multi #(.NUM_DIGITS(2), .TICK_DIV(4), .WRAP_MODE(1)) u_wrap (
        .i_clk   (clk),
        .i_reset (rst_n),
        .sw      (if_w)
    );

    stopwatch_bcd_multi #(.NUM_DIGITS(2), .TICK_DIV(4), .WRAP_MODE(0)) u_sat (
        .i_clk   (clk),
        .i_reset (rst_n),
        .sw      (if_s)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb_q.push_back(x);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t x;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            x = sb_q.pop_front();
            assert (obs === x.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
            end
            $display("t=%0t check %s observed=%h expected=%h", $time, x.tag, obs, x.exp);
        end
    endtask

    task automatic btn(input logic ss, input logic lp, input logic cl);
        if_w.i_start_stop = ss; if_w.i_lap = lp; if_w.i_clear = cl;
        if_s.i_start_stop = ss; if_s.i_lap = lp; if_s.i_clear = cl;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        btn(0, 0, 0);
        rst_n = 1'b0;
        step(2);
        push("rst_bcd_w", 8'h00);            pop_chk(32'(if_w.o_bcd));
        push("rst_seg_w", {7'h3F, 7'h3F});   pop_chk(32'(if_w.o_seg));
        push("rst_run_w", 1'b0);             pop_chk(32'(if_w.o_running));
        push("rst_lap_w", 1'b0);             pop_chk(32'(if_w.o_lap_active));
        push("rst_ovf_w", 1'b0);             pop_chk(32'(if_w.o_overflow));
        rst_n = 1'b1;
        step(1);

        // Start and run 40 cycles: ten increments.
        btn(1, 0, 0); step(1); btn(0, 0, 0);
        push("run40_bcd_w", 8'h10);
        push("run40_bcd_s", 8'h10);
        push("run40_seg_old", {7'h3F, 7'h6F});
        step(40);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_s.o_bcd));
        pop_chk(32'(if_w.o_seg));
        push("run40_seg_new", {7'h06, 7'h3F});
        step(1);
        pop_chk(32'(if_w.o_seg));

        // Up to 99.
        push("at99_bcd_w", 8'h99);
        push("at99_bcd_s", 8'h99);
        push("at99_ovf_w", 1'b0);
        step(355);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_s.o_bcd));
        pop_chk(32'(if_w.o_overflow));

        // One more tick: wrap vs saturate.
        push("wrap_bcd", 8'h00);
        push("wrap_ovf", 1'b1);
        push("wrap_run", 1'b1);
        push("sat_bcd", 8'h99);
        push("sat_ovf", 1'b1);
        push("sat_run", 1'b0);
        step(4);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_w.o_overflow));
        pop_chk(32'(if_w.o_running));
        pop_chk(32'(if_s.o_bcd));
        pop_chk(32'(if_s.o_overflow));
        pop_chk(32'(if_s.o_running));

        push("wrap8_bcd", 8'h02);
        push("sat8_bcd", 8'h99);
        push("sat8_run", 1'b0);
        push("sat8_ovf", 1'b1);
        step(8);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_s.o_bcd));
        pop_chk(32'(if_s.o_running));
        pop_chk(32'(if_s.o_overflow));

        // Second wrap keeps overflow sticky.
        push("wrap2_bcd", 8'h00);
        push("wrap2_ovf", 1'b1);
        push("wrap2_run", 1'b1);
        step(392);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_w.o_overflow));
        pop_chk(32'(if_w.o_running));

        // Reset both instances.
        rst_n = 1'b0;
        push("rst2_bcd_s", 8'h00);
        push("rst2_ovf_s", 1'b0);
        push("rst2_ovf_w", 1'b0);
        step(1);
        pop_chk(32'(if_s.o_bcd));
        pop_chk(32'(if_s.o_overflow));
        pop_chk(32'(if_w.o_overflow));
        rst_n = 1'b1;
        step(1);

        // Lap freeze at 23.
        btn(1, 0, 0); step(1); btn(0, 0, 0);
        push("to23_bcd_w", 8'h23);
        push("to23_bcd_s", 8'h23);
        step(92);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_s.o_bcd));
        btn(0, 1, 0);
        push("lap_on", 1'b1);
        step(1);
        pop_chk(32'(if_w.o_lap_active));
        btn(0, 0, 0);
        push("lap_bcd", 8'h28);
        push("lap_seg_w", {7'h5B, 7'h4F});
        push("lap_seg_s", {7'h5B, 7'h4F});
        push("lap_run", 1'b1);
        step(20);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_w.o_seg));
        pop_chk(32'(if_s.o_seg));
        pop_chk(32'(if_w.o_running));
        btn(0, 1, 0);
        push("unlap_seg_lat", {7'h5B, 7'h4F});
        step(1);
        pop_chk(32'(if_w.o_seg));
        btn(0, 0, 0);
        push("unlap_seg_live", {7'h5B, 7'h7F});
        push("unlap_lap", 1'b0);
        step(1);
        pop_chk(32'(if_w.o_seg));
        pop_chk(32'(if_w.o_lap_active));

        // Stop two cycles into a period, wait, resume.
        step(2);
        btn(1, 0, 0);
        push("stop_run", 1'b0);
        step(1);
        pop_chk(32'(if_w.o_running));
        btn(0, 0, 0);
        push("stopped_bcd", 8'h29);
        step(50);
        pop_chk(32'(if_w.o_bcd));
        btn(1, 0, 0);
        push("resume_run", 1'b1);
        step(1);
        pop_chk(32'(if_w.o_running));
        btn(0, 0, 0);
        push("resume1_bcd", 8'h29);
        step(1);
        pop_chk(32'(if_w.o_bcd));
        push("resume2_bcd_w", 8'h30);
        push("resume2_bcd_s", 8'h30);
        step(1);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_s.o_bcd));

        // Clear while running is ignored.
        btn(0, 0, 1);
        push("clr_run_bcd", 8'h30);
        push("clr_run_run", 1'b1);
        step(1);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_w.o_running));
        btn(0, 0, 0);
        push("to57_bcd", 8'h57);
        step(107);
        pop_chk(32'(if_w.o_bcd));
        btn(1, 0, 0); step(1); btn(0, 0, 0);
        push("stop57_run", 1'b0);
        step(1);
        pop_chk(32'(if_w.o_running));

        // Clear and start together in STOP.
        btn(1, 0, 1);
        push("clrss_bcd_w", 8'h00);
        push("clrss_bcd_s", 8'h00);
        push("clrss_run", 1'b1);
        step(1);
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_s.o_bcd));
        pop_chk(32'(if_w.o_running));
        btn(0, 0, 0);
        push("clrss_3cyc", 8'h00);
        step(3);
        pop_chk(32'(if_w.o_bcd));
        push("clrss_4cyc", 8'h01);
        step(1);
        pop_chk(32'(if_w.o_bcd));

        // Async reset in the middle of LAP at 45.
        push("to45_bcd", 8'h45);
        step(176);
        pop_chk(32'(if_w.o_bcd));
        btn(0, 1, 0);
        push("lap45_on", 1'b1);
        step(1);
        pop_chk(32'(if_w.o_lap_active));
        btn(0, 0, 0);
        #2;
        rst_n = 1'b0;
        push("arst_bcd", 8'h00);
        push("arst_seg", {7'h3F, 7'h3F});
        push("arst_run", 1'b0);
        push("arst_lap", 1'b0);
        push("arst_ovf", 1'b0);
        #1;
        pop_chk(32'(if_w.o_bcd));
        pop_chk(32'(if_w.o_seg));
        pop_chk(32'(if_w.o_running));
        pop_chk(32'(if_w.o_lap_active));
        pop_chk(32'(if_w.o_overflow));
        step(1);
        rst_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
